// File: rtl/usb_nrzi_tx.sv
// USB full-speed packet transmitter: SYNC, bit stuffing, NRZI line coding and EOP generation.
// One-byte holding register in front of an 8-bit shift register, LSB first.
module usb_nrzi_tx #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       d_plus,
   output logic       d_minus,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CntMax = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {StIdle, StSync, StData, StEopSe0, StEopJ} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    sr_q, sr_d;
   logic [2:0]    idx_q, idx_d;
   logic          last_q, last_d;
   logic [2:0]    ones_q, ones_d;
   logic          dp_q, dp_d, dm_q, dm_d;
   logic [7:0]    hold_q, hold_d;
   logic          hold_last_q, hold_last_d;
   logic          hold_vld_q, hold_vld_d;
   logic          done_q, done_d, err_q, err_d;

   logic          bit_end;
   logic          send_bit;
   logic          send_raw;
   logic [2:0]    idx_nxt;

   assign bit_end = (cnt_q == CntMax);
   assign idx_nxt = idx_q + 3'd1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = (state_q == StIdle || bit_end) ? '0 : cnt_q + CW'(1);
      sr_d        = sr_q;
      idx_d       = idx_q;
      last_d      = last_q;
      ones_d      = ones_q;
      dp_d        = dp_q;
      dm_d        = dm_q;
      hold_d      = hold_q;
      hold_last_d = hold_last_q;
      hold_vld_d  = hold_vld_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      send_bit    = 1'b0;
      send_raw    = 1'b0;

      if (tx_valid && !hold_vld_q) begin
         hold_d      = tx_data;
         hold_last_d = tx_last;
         hold_vld_d  = 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (tx_start) begin
               state_d  = StSync;
               sr_d     = 8'h80;
               idx_d    = '0;
               last_d   = 1'b0;
               ones_d   = '0;
               send_bit = 1'b1;
               send_raw = 1'b0;
            end
         end
         StSync, StData: begin
            if (bit_end) begin
               if (ones_q == 3'd6) begin
                  // Stuffed zero: toggle the line without consuming a data bit.
                  dp_d   = dm_q;
                  dm_d   = dp_q;
                  ones_d = '0;
               end else if (idx_q != 3'd7) begin
                  idx_d    = idx_nxt;
                  send_bit = 1'b1;
                  send_raw = sr_q[idx_nxt];
               end else if (last_q) begin
                  state_d = StEopSe0;
                  idx_d   = '0;
                  dp_d    = 1'b0;
                  dm_d    = 1'b0;
               end else if (hold_vld_q) begin
                  state_d    = StData;
                  sr_d       = hold_q;
                  last_d     = hold_last_q;
                  hold_vld_d = 1'b0;
                  idx_d      = '0;
                  send_bit   = 1'b1;
                  send_raw   = hold_q[0];
               end else begin
                  err_d   = 1'b1;
                  state_d = StEopSe0;
                  idx_d   = '0;
                  dp_d    = 1'b0;
                  dm_d    = 1'b0;
               end
            end
         end
         StEopSe0: begin
            if (bit_end) begin
               if (idx_q == 3'd0) begin
                  idx_d = 3'd1;
               end else begin
                  state_d = StEopJ;
                  dp_d    = 1'b1;
                  dm_d    = 1'b0;
               end
            end
         end
         StEopJ: begin
            if (bit_end) begin
               state_d = StIdle;
               done_d  = 1'b1;
               idx_d   = '0;
               ones_d  = '0;
            end
         end
         default: state_d = StIdle;
      endcase

      // NRZI: raw 0 toggles between J and K, raw 1 holds the line.
      if (send_bit) begin
         if (!send_raw) begin
            dp_d   = dm_q;
            dm_d   = dp_q;
            ones_d = '0;
         end else begin
            ones_d = ones_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         sr_q        <= '0;
         idx_q       <= '0;
         last_q      <= 1'b0;
         ones_q      <= '0;
         dp_q        <= 1'b1;
         dm_q        <= 1'b0;
         hold_q      <= '0;
         hold_last_q <= 1'b0;
         hold_vld_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         idx_q       <= idx_d;
         last_q      <= last_d;
         ones_q      <= ones_d;
         dp_q        <= dp_d;
         dm_q        <= dm_d;
         hold_q      <= hold_d;
         hold_last_q <= hold_last_d;
         hold_vld_q  <= hold_vld_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign tx_ready = ~hold_vld_q;
   assign d_plus   = dp_q;
   assign d_minus  = dm_q;
   assign tx_busy  = (state_q != StIdle);
   assign tx_done  = done_q;
   assign tx_err   = err_q;

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Scoreboard bench for usb_nrzi_tx: a bit-stream model queues expected line symbols per packet,
// a monitor samples the line mid bit period and compares.
module tb_usb_nrzi_tx;

   localparam int unsigned P = 4;
   localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_last = 1'b0;
   logic       tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_err;

   int checks = 0;
   int fails = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int pkts_sent = 0;
   int pkts_done = 0;

   logic [1:0] sym_q[$];
   int         len_q[$];
   int         experr_q[$];
   logic [7:0] pkt[$];

   usb_nrzi_tx #(.CLKS_PER_BIT(P)) dut (
      .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready), .d_plus(d_plus),
      .d_minus(d_minus), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tx_done) done_cnt <= done_cnt + 1;
      if (tx_err) err_cnt <= err_cnt + 1;
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Expected line: SYNC + bytes LSB first, zero inserted after six ones, NRZI from J, then EOP.
   task automatic model_packet(input int underrun);
      bit         raw[$];
      logic [1:0] line;
      int         ones;
      int         n;
      line = LJ;
      ones = 0;
      n = 0;
      for (int i = 0; i < 8; i++) raw.push_back(i == 7);
      foreach (pkt[i]) for (int b = 0; b < 8; b++) raw.push_back(pkt[i][b]);
      foreach (raw[i]) begin
         if (!raw[i]) line = (line == LJ) ? LK : LJ;
         ones = raw[i] ? ones + 1 : 0;
         sym_q.push_back(line);
         n++;
         if (ones == 6) begin
            line = (line == LJ) ? LK : LJ;
            ones = 0;
            sym_q.push_back(line);
            n++;
         end
      end
      sym_q.push_back(LSE0);
      sym_q.push_back(LSE0);
      sym_q.push_back(LJ);
      len_q.push_back(n + 3);
      experr_q.push_back(underrun);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push_byte(input logic [7:0] b, input logic l);
      int w;
      w = 0;
      tx_valid = 1'b1;
      tx_data = b;
      tx_last = l;
      while (!tx_ready && w < 400) begin
         @(negedge clk);
         w++;
      end
      if (w >= 400) begin
         checks++;
         fails++;
         $display("FAIL push_timeout: got tx_ready 0 expected 1");
      end
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic send_packet(input int underrun, input int inject);
      int n;
      int w;
      n = pkt.size();
      model_packet(underrun);
      pkts_sent++;
      @(negedge clk);
      push_byte(pkt[0], (underrun == 0) && (n == 1));
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      fork
         begin
            for (int i = 1; i < n; i++) push_byte(pkt[i], (underrun == 0) && (i == n - 1));
         end
         begin
            if (inject != 0) begin
               repeat (12 * P) @(negedge clk);
               tx_start = 1'b1;
               @(negedge clk);
               tx_start = 1'b0;
            end
         end
      join
      w = 0;
      while (pkts_done < pkts_sent && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 3000) begin
         checks++;
         fails++;
         $display("FAIL packet_timeout: got %0d packets expected %0d", pkts_done, pkts_sent);
      end
      repeat (3) @(negedge clk);
      check("idle_line", {d_plus, d_minus}, LJ);
      check("idle_busy", tx_busy, 0);
   endtask

   // Monitor: one bit-period sample per expected symbol, then EOP/done/err bookkeeping.
   initial begin
      int n, e, e0, d0;
      logic [1:0] exp;
      forever begin
         @(negedge clk);
         if (tx_busy && len_q.size() > 0) begin
            n = len_q.pop_front();
            e = experr_q.pop_front();
            e0 = err_cnt;
            d0 = done_cnt;
            for (int k = 0; k < n; k++) begin
               if (k > 0) repeat (P) @(negedge clk);
               exp = sym_q.pop_front();
               check($sformatf("line_bit%0d", k), {d_plus, d_minus}, exp);
            end
            repeat (P) @(negedge clk);
            check("busy_after_eop", tx_busy, 0);
            check("done_pulse", tx_done, 1);
            @(negedge clk);
            check("done_count", done_cnt - d0, 1);
            check("err_count", err_cnt - e0, e);
            pkts_done++;
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_dp", d_plus, 1);
      check("rst_dm", d_minus, 0);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", tx_busy, 0);
      n_rst = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_no_activity", {d_plus, d_minus, tx_busy}, {LJ, 1'b0});

      pkt = {8'hA5};             send_packet(0, 0);
      pkt = {8'hFF};             send_packet(0, 0);
      pkt = {8'h00, 8'h3C};      send_packet(0, 0);
      pkt = {8'h01};             send_packet(1, 0);
      pkt = {8'hA5, 8'h5A};      send_packet(0, 1);
      pkt = {8'hFC};             send_packet(0, 0);
      pkt = {8'hFC};             send_packet(1, 0);
      pkt = {8'hFF, 8'hFF, 8'h7F}; send_packet(0, 0);

      for (int r = 0; r < 14; r++) begin
         int nb;
         nb = $urandom_range(1, 3);
         pkt = {};
         for (int i = 0; i < nb; i++)
            pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
         send_packet(($urandom_range(0, 4) == 0) ? 1 : 0, $urandom_range(0, 1));
      end

      // Asynchronous reset in the middle of a data byte, no scoreboard entry.
      @(negedge clk);
      push_byte(8'hA5, 1'b1);
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (10 * P) @(negedge clk);
      push_byte(8'h33, 1'b0);
      #2 n_rst = 1'b0;
      #1;
      check("midrst_dp", d_plus, 1);
      check("midrst_dm", d_minus, 0);
      check("midrst_busy", tx_busy, 0);
      check("midrst_ready", tx_ready, 1);
      check("midrst_done_err", {tx_done, tx_err}, 0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      repeat (12) @(negedge clk);
      check("post_rst_idle", {d_plus, d_minus, tx_busy, tx_ready}, {LJ, 1'b0, 1'b1});

      pkt = {8'hA5};
      send_packet(0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
